writeback_stage: RTL
====================

// Module: writeback_stage
// PURPOSE
//  Last pipeline stage of the rv32i core; sits directly upstream of register_file and drives its write port.
//  Retires execute results: ALU results are committed directly.
//  Loads issue one word read to data memory, then extract, sign/zero-extend and commit.
//  Flags misaligned/illegal loads and memory timeouts; never writes x0.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in MEM_WAIT before abort (>=2)
// PORTS
//  clock                       in   1   single clock, rising edge
//  reset                       in   1   synchronous, active-high
//  ex_valid                    in   1   execute presents a result
//  ex_ready                    out  1   stage can accept (comb: state==IDLE && !reset)
//  ex_rd                       in   5   destination register
//  ex_result                   in   32  ALU result, or byte address for loads
//  ex_is_load                  in   1   1 = load, 0 = ALU op
//  ex_funct3                   in   3   load type: 0 LB,1 LH,2 LW,4 LBU,5 LHU
//  mem_req                     out  1   read request, level held during MEM_WAIT
//  mem_addr                    out  32  {addr[31:2],2'b00}
//  mem_rvalid                  in   1   read data valid (sampled only in MEM_WAIT)
//  mem_rdata                   in   32  little-endian word
//  register_file_write_enable  out  1   one-cycle write strobe to register_file
//  rd                          out  5   write address
//  rd_value                    out  32  write data
//  misaligned_error            out  1   one-cycle pulse
//  timeout_error               out  1   one-cycle pulse
// BEHAVIOUR
//  Reset: state IDLE, timeout counter 0.
//   All registered outputs 0: mem_req, mem_addr, register_file_write_enable, rd, rd_value, both errors.
//   Any pending load is abandoned; a mem_rvalid seen after reset is ignored.
//  Accept: ex_valid && ex_ready at a rising edge. All outputs are registered.
//  States:
//   IDLE -> IDLE on accept of an ALU op.
//    Next cycle: write_enable=(ex_rd!=0), rd=ex_rd, rd_value=ex_result.
//    Back-to-back ALU ops retire 1 per cycle.
//   IDLE -> MEM_WAIT on accept of a legal, aligned load.
//    Latch rd, funct3 and addr[1:0].
//    Next cycle: mem_req=1, mem_addr=word address.
//   IDLE -> IDLE on accept of a bad load; no mem_req, no write, misaligned_error=1 next cycle.
//    Bad = funct3 in {3,6,7}, or LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
//   MEM_WAIT -> IDLE on mem_rvalid.
//    Next cycle: mem_req=0, write_enable=(rd!=0), rd_value=extracted data.
//   MEM_WAIT -> IDLE on timeout.
//    Counter increments each MEM_WAIT edge without rvalid.
//    Timeout when counter==TIMEOUT_CYCLES-1 with no rvalid.
//    Next cycle: mem_req=0, timeout_error=1, no write; counter cleared.
//   rvalid at the timeout edge: data wins, no error.
//  Extraction: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
//   LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
//  Strobes (write_enable and both errors) are high exactly one cycle and otherwise 0.
//   rd and rd_value hold their last values.
//  mem_rvalid while in IDLE is ignored.
//  ex_ready=0 throughout MEM_WAIT.
//   A load accepted at edge N with rvalid on the first MEM_WAIT cycle retires at edge N+1.
//   The next instruction is accepted at edge N+2.
//  rd==0: result is computed and the load is still performed; write_enable stays 0.
// TESTING
//  ALU x5=0x12345678 then x6=0xFFFFFFFF on consecutive cycles:
//   -> two consecutive 1-cycle strobes with matching rd/rd_value.
//  LB addr 0x103, rdata 0x80FF7F01:
//   -> mem_addr 0x100, rd_value 0xFFFFFF80.
//   LBU on the same data -> 0x00000080.
//   LHU addr 0x102 -> 0x000080FF.
//  LW addr 0x202, and funct3=3:
//   -> misaligned_error pulses; mem_req and write_enable stay 0; ex_ready stays 1.
//  LW, rvalid withheld:
//   -> mem_req high exactly 16 cycles, then timeout_error pulse, no write.
//   A later rvalid in IDLE is ignored.
//  ALU op with rd=0, value 0xDEADBEEF -> write_enable stays 0.
//  Reset asserted mid-MEM_WAIT -> next cycle all outputs 0, IDLE.
//   An rvalid arriving afterwards causes no write.

Source files
------------

// File: rtl/writeback_stage.sv
// Final rv32i pipeline stage: commits ALU results directly and performs
// single-word data-memory reads for loads, driving the register_file write port.
module writeback_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_funct3,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        register_file_write_enable,
    output logic [4:0]  rd,
    output logic [31:0] rd_value,
    output logic        misaligned_error,
    output logic        timeout_error
);

    localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned CNT_MAX = TIMEOUT_CYCLES - 1;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_count;
    logic [4:0]         load_rd;
    logic [2:0]         load_funct3;
    logic [1:0]         load_offset;
    logic               accept;

    // Illegal funct3 or a halfword/word address not naturally aligned.
    function automatic logic is_bad_load(input logic [2:0] funct3, input logic [1:0] offset);
        logic bad;
        case (funct3)
            3'd0, 3'd4: bad = 1'b0;
            3'd1, 3'd5: bad = offset[0];
            3'd2:       bad = (offset != 2'd0);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] funct3, input logic [1:0] offset,
                                            input logic [31:0] word);
        logic [31:0] byte_shift;
        logic [31:0] half_shift;
        logic [31:0] value;
        byte_shift = word >> {offset, 3'b000};
        half_shift = word >> {offset[1], 4'b0000};
        case (funct3)
            3'd0:    value = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'd1:    value = {{16{half_shift[15]}}, half_shift[15:0]};
            3'd4:    value = {24'd0, byte_shift[7:0]};
            3'd5:    value = {16'd0, half_shift[15:0]};
            default: value = word;
        endcase
        return value;
    endfunction

    assign ex_ready = (state == IDLE) && !reset;
    assign accept   = ex_valid && ex_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state                      <= IDLE;
            wait_count                 <= '0;
            load_rd                    <= '0;
            load_funct3                <= '0;
            load_offset                <= '0;
            mem_req                    <= 1'b0;
            mem_addr                   <= '0;
            register_file_write_enable <= 1'b0;
            rd                         <= '0;
            rd_value                   <= '0;
            misaligned_error           <= 1'b0;
            timeout_error              <= 1'b0;
        end else begin
            // Strobes default low so each pulse lasts exactly one cycle.
            register_file_write_enable <= 1'b0;
            misaligned_error           <= 1'b0;
            timeout_error              <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!ex_is_load) begin
                            register_file_write_enable <= (ex_rd != 5'd0);
                            rd                         <= ex_rd;
                            rd_value                   <= ex_result;
                        end else if (is_bad_load(ex_funct3, ex_result[1:0])) begin
                            misaligned_error <= 1'b1;
                        end else begin
                            load_rd     <= ex_rd;
                            load_funct3 <= ex_funct3;
                            load_offset <= ex_result[1:0];
                            mem_req     <= 1'b1;
                            mem_addr    <= {ex_result[31:2], 2'b00};
                            wait_count  <= '0;
                            state       <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    // Returning data takes priority over a simultaneous timeout.
                    if (mem_rvalid) begin
                        mem_req                    <= 1'b0;
                        register_file_write_enable <= (load_rd != 5'd0);
                        rd                         <= load_rd;
                        rd_value                   <= extract(load_funct3, load_offset, mem_rdata);
                        wait_count                 <= '0;
                        state                      <= IDLE;
                    end else if (wait_count == CNT_W'(CNT_MAX)) begin
                        mem_req       <= 1'b0;
                        timeout_error <= 1'b1;
                        wait_count    <= '0;
                        state         <= IDLE;
                    end else begin
                        wait_count <= wait_count + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
